uart_tx_writer: RTL and testbench

//  8N1 UART transmitter: serialises one byte per frame onto tx_pin, LSB first, idle-high.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_writer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive stages.
// Latency: none; constants, state encoding and a helper function only.
// Backpressure: not applicable.
package uart_pkg;

    localparam int DATA_BITS    = 8;
    localparam int CLK_FREQ_DEF = 50000000;
    localparam int BAUD_DEF     = 115200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per line bit; integer division, remainder dropped.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter: bit_end pulses on the last clock of every bit period.
// Latency: bit_end is high while the count sits at CLKS_PER_BIT-1; restart zeroes the count next edge.
// Backpressure: none; free-running unless restarted.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    // Next count: wrap at the end of a bit, or start a fresh bit when a frame is loaded.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_writer.sv
// 8N1 UART transmitter with a one-byte holding register for back-to-back frames.
// Latency: tx_pin falls one edge after the accepting edge when idle; a frame is 10*CLKS_PER_BIT clocks.
// Backpressure: tx_ready low while the holding register is full; tx_valid ignored until it drains.
module uart_tx_writer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic                 clock_50mhz,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BIW          = $clog2(DATA_BITS);
    localparam logic [BIW-1:0] LAST_IDX = BIW'(DATA_BITS - 1);

    // A bit period shorter than two clocks cannot be timed by the baud counter.
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx_writer: CLKS_PER_BIT must be >= 2");
    end

    uart_state_e          state_q,     state_d;
    logic [BIW-1:0]       bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] hold_q,      hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_pin_q,    tx_pin_d;
    logic                 busy_q,      busy_d;
    logic                 tx_done_q,   tx_done_d;
    logic                 load;
    logic                 bit_end;
    logic [BIW-1:0]       next_idx;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clock_50mhz),
        .rst_n   (reset_n),
        .restart (load),
        .bit_end (bit_end)
    );

    assign tx_ready = !hold_full_q;
    assign tx_pin   = tx_pin_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

    // Next state: accept into the hold, walk start/data/stop, reload from the hold when free.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_pin_d    = tx_pin_q;
        busy_d      = busy_q;
        tx_done_d   = 1'b0;
        load        = 1'b0;
        next_idx    = bit_idx_q + BIW'(1);

        // Accept only into an empty hold; a load needs a full hold, so the two never collide.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_pin_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d  = STOP;
                        tx_pin_d = 1'b1;
                    end else begin
                        bit_idx_d = next_idx;
                        tx_pin_d  = shift_q[next_idx];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_d = 1'b1;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Drain the hold into the shifter and drive the start bit immediately.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_pin_d    = 1'b0;
            busy_d      = 1'b1;
            state_d     = START;
        end
    end

    // State and datapath registers; reset abandons any frame in flight and the held byte.
    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_pin_q    <= 1'b1;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_pin_q    <= tx_pin_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_writer.sv
// Self-checking bench: frame-level line monitor plus a mid-bit sampling receiver at default rate.
// Latency: n/a.
// Backpressure: driver waits on tx_ready before presenting each byte.
module tb_uart_tx_writer;

    localparam int CPB     = 800 / 100;
    localparam int FRAME   = 10 * CPB;
    localparam int DEF_CPB = 50000000 / 115200;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_pin;
    logic       busy;
    logic       tx_done;

    logic [7:0] d_data;
    logic       d_valid;
    logic       d_ready;
    logic       d_pin;
    logic       d_busy;
    logic       d_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         acc_cyc;
    bit         mon_en  = 1'b0;
    bit         mon_in  = 1'b0;
    int         mon_off = 0;
    logic [7:0] mon_byte;

    uart_tx_writer #(.CLK_FREQ(800), .BAUD(100)) u_dut (
        .clock_50mhz (clk),
        .reset_n     (reset_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_pin      (tx_pin),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    uart_tx_writer u_dut_def (
        .clock_50mhz (clk),
        .reset_n     (reset_n),
        .tx_data     (d_data),
        .tx_valid    (d_valid),
        .tx_ready    (d_ready),
        .tx_pin      (d_pin),
        .busy        (d_busy),
        .tx_done     (d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for timing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Line level of frame bit j: start 0, data LSB first, stop 1.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Frame monitor: every clock of every frame is compared against the expected byte.
    always @(negedge clk) begin
        bit was_end;
        was_end = 1'b0;
        if (!mon_en) begin
            mon_in = 1'b0;
        end else begin
            if (mon_in) begin
                mon_off = mon_off + 1;
                if (mon_off == FRAME) begin
                    check("tx_done_at_stop_end", tx_done, 1);
                    mon_in  = 1'b0;
                    was_end = 1'b1;
                end else begin
                    check("line_bit", tx_pin, frame_bit(mon_byte, mon_off / CPB));
                    check("busy_in_frame", busy, 1);
                    check("tx_done_mid_frame", tx_done, 0);
                end
            end
            if (!mon_in) begin
                if (tx_pin === 1'b0 && exp_q.size() > 0) begin
                    mon_byte = exp_q.pop_front();
                    mon_in   = 1'b1;
                    mon_off  = 0;
                    start_cyc.push_back(cyc);
                    check("busy_at_start", busy, 1);
                end else begin
                    check("idle_line", tx_pin, 1);
                    check("idle_busy", busy, 0);
                end
                if (!was_end) check("tx_done_idle", tx_done, 0);
            end
            check("tx_ready", tx_ready, (exp_q.size() == 0) ? 1 : 0);
        end
    end

    task automatic send(input logic [7:0] b);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            if (tx_ready) begin
                tx_data = b;
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                exp_q.push_back(b);
                tx_valid = 1'b0;
                done = 1'b1;
            end else begin
                tx_data = 8'($urandom);
            end
        end
        if (!done) timeout("send_accept");
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !mon_in) done = 1'b1;
        end
        if (!done) timeout("drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic rx_def(output logic [7:0] b);
        bit seen;
        seen = 1'b0;
        b = 8'h00;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            if (d_pin === 1'b0) seen = 1'b1;
        end
        if (!seen) begin
            timeout("loopback_start");
        end else begin
            repeat (DEF_CPB / 2) @(negedge clk);
            check("loopback_start_bit", d_pin, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (DEF_CPB) @(negedge clk);
                b[i] = d_pin;
            end
            repeat (DEF_CPB) @(negedge clk);
            check("loopback_stop_bit", d_pin, 1);
        end
    endtask

    initial begin
        int base;
        logic [7:0] rx_b;
        logic [7:0] lb[3];

        // 1: reset held for three edges with tx_valid asserted
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        d_valid  = 1'b0;
        d_data   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_pin", tx_pin, 1);
        check("reset_busy", busy, 0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_tx_done", tx_done, 0);
        tx_valid = 1'b0;
        reset_n  = 1'b1;
        mon_en   = 1'b1;
        repeat (20) @(negedge clk);

        // 2: single byte, latency from accept to start fall
        base = start_cyc.size();
        send(8'hA3);
        drain();
        check("a3_frames", start_cyc.size() - base, 1);
        if (start_cyc.size() > base) check("a3_latency", start_cyc[base] - acc_cyc, 1);

        // 3: second byte accepted while the first shifts; frames abut
        base = start_cyc.size();
        send(8'h55);
        send(8'h0F);
        drain();
        check("b2b_frames", start_cyc.size() - base, 2);
        if (start_cyc.size() > base + 1) check("b2b_gap", start_cyc[base+1] - start_cyc[base], FRAME);

        // 4: sustained stream with garbage data while not ready
        base = start_cyc.size();
        send(8'h00);
        send(8'hFF);
        send(8'h81);
        drain();
        check("stream_frames", start_cyc.size() - base, 3);
        if (start_cyc.size() > base + 2) begin
            check("stream_gap1", start_cyc[base+1] - start_cyc[base], FRAME);
            check("stream_gap2", start_cyc[base+2] - start_cyc[base+1], FRAME);
        end

        // 5: reset during data bit 4 with a byte in the hold
        send(8'hF0);
        send(8'h77);
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 400 && !hit; c++) begin
                @(posedge clk);
                if (mon_in && mon_off == 5 * CPB + 2) hit = 1'b1;
            end
            if (!hit) timeout("reach_bit4");
        end
        @(negedge clk);
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        @(posedge clk);
        @(negedge clk);
        check("midreset_tx_pin", tx_pin, 1);
        check("midreset_busy", busy, 0);
        check("midreset_tx_ready", tx_ready, 1);
        check("midreset_tx_done", tx_done, 0);
        exp_q.delete();
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        mon_en   = 1'b1;
        repeat (FRAME + 20) @(negedge clk);
        send(8'h3C);
        drain();

        // random bytes with random idle gaps
        base = start_cyc.size();
        for (int i = 0; i < 12; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 100);
            send(8'($urandom));
            repeat (gap) @(negedge clk);
        end
        drain();
        check("random_frames", start_cyc.size() - base, 12);

        // 6: default-rate instance sampled mid-bit by a behavioural receiver
        lb[0] = 8'h00;
        lb[1] = 8'h5A;
        lb[2] = 8'hFF;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    bit ok;
                    ok = 1'b0;
                    for (int c = 0; c < 6000 && !ok; c++) begin
                        @(negedge clk);
                        if (d_ready) begin
                            d_valid = 1'b1;
                            d_data  = lb[i];
                            @(posedge clk);
                            #1;
                            d_valid = 1'b0;
                            ok = 1'b1;
                        end
                    end
                    if (!ok) timeout("loopback_accept");
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    rx_def(rx_b);
                    check("loopback_byte", rx_b, lb[i]);
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
